// File: rtl/bus_grant_arbiter_pkg.sv
// Shared definitions for the datapath bus arbiter: bus geometry, FSM states
// and the index of each bus source.
package bus_arb_pkg;

    localparam int N_BUS_SRC = 32;
    localparam int BUS_SEL_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } arb_state_t;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_C      = 23;

endpackage

// File: rtl/bus_grant_arbiter_if.sv
// Request/grant bundle between the bus sources (master) and the arbiter (slave).
interface bus_grant_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int N     = N_BUS_SRC,
    parameter int SEL_W = BUS_SEL_W
);
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_sel;
    logic             gnt_valid;
    logic             timeout;

    modport master (output req, mask, input gnt, gnt_sel, gnt_valid, timeout);
    modport slave  (input req, mask, output gnt, gnt_sel, gnt_valid, timeout);
endinterface

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible source at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N     = N_BUS_SRC,
    parameter int SEL_W = BUS_SEL_W
) (
    input  logic [N-1:0]     elig,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win_idx,
    output logic [N-1:0]     win_onehot
);
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;

    // NOTE: every output and temporary gets a default before any branch so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        any        = |elig;
        rot        = N'({elig, elig} >> ptr);
        off        = '0;
        win_onehot = '0;
        // Downward scan leaves the lowest set bit of the rotated vector.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        win_idx = off + ptr;
        if (any) win_onehot[win_idx] = 1'b1;
    end
endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant, bounded hold time and a
// dead turnaround cycle between successive owners.
module bus_grant_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N        = N_BUS_SRC,
    parameter int SEL_W    = BUS_SEL_W,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              clr,
    bus_grant_arbiter_if.slave bus
);
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [N-1:0]     elig;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N-1:0]     pick_onehot;

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       cnt_q, cnt_d;

    assign elig = bus.req & ~bus.mask;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .elig       (elig),
        .ptr        (ptr_q),
        .any        (pick_any),
        .win_idx    (pick_idx),
        .win_onehot (pick_onehot)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    sel_d   = pick_idx;
                    gnt_d   = pick_onehot;
                    valid_d = 1'b1;
                    cnt_d   = 8'd1;
                end
            end
            OWN: begin
                if (elig[sel_q] && cnt_q < HOLD_LIMIT) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // A still-eligible owner here can only mean the hold limit hit.
                    timeout_d = elig[sel_q];
                    state_d   = TURN;
                    ptr_d     = sel_q + SEL_W'(1);
                    sel_d     = '0;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    cnt_d     = '0;
                end
            end
            TURN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_sel   = sel_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: doc/bus_grant_arbiter.md
Name: bus_grant_arbiter

Overview:
- Round-robin arbiter for the shared 32-bit datapath bus. Up to 32 sources request the bus: R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C and spares.
- Issues a registered one-hot grant (`gnt`) that drives the source's bus-output enable, and the matching 5-bit encoded select (`gnt_sel`) for the bus mux.
- Guarantees exactly zero or one driver per cycle, fair rotation, bounded hold time and a dead turnaround cycle between owners.

Parameters:
- N, 32, number of requesters; must be a power of two, at least 2.
- SEL_W, 5, width of the encoded select; equals log2(N).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the bus before forced release; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  asynchronous reset, active-high; clears all state immediately.
- req  in  N  per-source bus request; level-sensitive.
- mask  in  N  per-source disable; 1 = ignore that source's `req`.
- gnt  out  N  registered one-hot grant; all-zero when no owner.
- gnt_sel  out  SEL_W  encoded index of the current owner; 0 when `gnt_valid` = 0.
- gnt_valid  out  1  1 while an owner holds the bus.
- timeout  out  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.

Behaviour:
- Reset (async, `clr` = 1):
  - `gnt` = 0, `gnt_sel` = 0, `gnt_valid` = 0, `timeout` = 0.
  - State = IDLE, rotation pointer `ptr` = 0, hold counter = 0.
  - Asserting `clr` mid-ownership drops `gnt` in the same cycle, without waiting for a clock edge.
- Eligible set: `elig = req & ~mask`.
- FSM states: IDLE, OWN, TURN.
  - IDLE, `elig` = 0: stay in IDLE.
  - IDLE, `elig` ≠ 0: pick the first set bit of `elig` searching upward from `ptr`, wrapping N-1 → 0. Next edge: `gnt` = one-hot of winner, `gnt_sel` = winner index, `gnt_valid` = 1, state = OWN, hold counter = 1.
  - Latency is 1 cycle from `req` sampled high in IDLE to `gnt` high.
  - OWN: owner keeps `gnt` while `elig[owner]` = 1 and hold counter < MAX_HOLD; the counter increments each cycle.
  - OWN release (`elig[owner]` = 0, by either `req` drop or `mask` set): next edge clears `gnt`, sets `ptr` = (owner+1) mod N, state = TURN.
  - OWN forced release (`elig[owner]` still 1 and counter = MAX_HOLD): same as a normal release, plus `timeout` = 1 for exactly that one cycle.
  - Simultaneous requester drop and counter = MAX_HOLD is a normal release; no `timeout` pulse.
  - TURN: one dead cycle with `gnt` = 0, then IDLE. No arbitration happens in TURN, so back-to-back owners are separated by at least 2 cycles of `gnt` = 0 (TURN, then the IDLE pick cycle).
- Grant duration: an owner holds `gnt` for at most MAX_HOLD consecutive cycles.
- Pointer rules:
  - `ptr` updates only on release.
  - Wrap-around: owner N-1 → `ptr` = 0.
  - A released owner that still requests is searched last in the next round.
- `mask` changes on requesters other than the owner take effect at the next arbitration only.
- Invariant: `gnt` is always one-hot or zero. `gnt_sel` always equals the encoded index of `gnt`. `gnt_valid` = |`gnt`.
- All outputs come directly from flops; there is no combinational path from `req` to `gnt`.

Decomposition:
- Shared package `bus_arb_pkg`:
  - constants N_BUS_SRC = 32, BUS_SEL_W = 5;
  - state enum {IDLE, OWN, TURN};
  - named source-index constants (SRC_R0…SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C).
- Sub-module `rr_pick`: purely combinational; inputs `elig`[N] and `ptr`[SEL_W]; outputs `any`, `win_idx`[SEL_W], `win_onehot`[N].
  - Implemented by rotating `elig` right by `ptr`, priority-encoding the lowest set bit, then adding `ptr` mod N.
  - The top level holds the FSM, pointer, hold counter and output registers.

Test Plan:
- Reset, then `req` = 0x0000_0004 held for 3 cycles and dropped → cycle 1 `gnt` = 0x4, `gnt_sel` = 2; `gnt` held 3 cycles; `ptr` becomes 3; one TURN cycle, then IDLE.
- `req` = 0x8000_0001 continuously from reset, MAX_HOLD = 4 → grants alternate: idx 0 for 4 cycles (`timeout` pulses), then idx 31 for 4 cycles (`timeout` pulses); `ptr` wraps to 0; idx 0 granted again.
- Owner idx 5 drops `req` on the exact cycle its counter reaches MAX_HOLD → normal release, `timeout` stays 0, `ptr` = 6.
- `req` = 0xFFFF_FFFF, `mask` = 0xFFFF_FFFE → only idx 0 is ever granted; then set `mask[0]` during ownership → `gnt` clears next edge.
- `clr` asserted mid-OWN between clock edges → `gnt`, `gnt_valid` and `gnt_sel` go to 0 immediately; after release, lowest requester from `ptr` = 0 wins.
- Random `req`/`mask` for 10k cycles with assertions: `gnt` one-hot-or-zero; `gnt_sel` == encode(`gnt`); no owner exceeds MAX_HOLD; every eligible requester is granted within N×(MAX_HOLD+2) cycles.
